// File: rtl/switch_state_decoder.sv
// rtl/switch_state_decoder.sv - switch status receive decoder: stability filter, toggle counter, error flags
// Optional build macro SWITCH_DEC_GLITCH_CNT_EN adds the glitch_cnt output.
module switch_state_decoder #(
  parameter int STABLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       code_in,
  input  logic [2:0]       num_in,
  input  logic             err_clr,
  output logic [1:0]       state_out,
  output logic             state_valid,
  output logic             toggle,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             err_illegal,
  output logic             err_mismatch
`ifdef SWITCH_DEC_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  localparam int              RUN_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  localparam logic [1:0] ST_UNK  = 2'b00;
  localparam logic [1:0] ST_ON   = 2'b01;
  localparam logic [1:0] ST_OFF  = 2'b10;
  localparam logic [1:0] ST_IDLE = 2'b11;

  localparam logic [1:0] CODE_IDLE = 2'h0;
  localparam logic [1:0] CODE_ON   = 2'h1;
  localparam logic [1:0] CODE_BAD  = 2'h2;
  localparam logic [1:0] CODE_OFF  = 2'h3;

  localparam logic [2:0] NUM_IDLE = 3'h0;
  localparam logic [2:0] NUM_ON   = 3'h2;
  localparam logic [2:0] NUM_OFF  = 3'h4;

  logic [1:0]       code_q;
  logic [1:0]       cand;
  logic [RUN_W-1:0] run;
  logic             arm;
  logic [1:0]       state;

  logic             code_legal;
  logic [RUN_W-1:0] next_run;
  logic [1:0]       dec_state;
  logic [2:0]       exp_num;
  logic             commit;
  logic             is_toggle;
  logic             mismatch_set;

  assign code_legal = (code_q != CODE_BAD);

  always_comb begin
    next_run = RUN_W'(1);
    if (code_q == cand)
      next_run = (run >= RUN_MAX) ? RUN_MAX : run + RUN_W'(1);
  end

  always_comb begin
    dec_state = ST_IDLE;
    exp_num   = NUM_IDLE;
    case (code_q)
      CODE_ON:  begin dec_state = ST_ON;  exp_num = NUM_ON;  end
      CODE_OFF: begin dec_state = ST_OFF; exp_num = NUM_OFF; end
      CODE_IDLE: begin dec_state = ST_IDLE; exp_num = NUM_IDLE; end
      default:  begin dec_state = state;  exp_num = num_in;  end
    endcase
  end

  assign commit    = code_legal && (next_run == RUN_MAX) && (dec_state != state);
  // Only ON<->OFF counts as a toggle; leaving UNK or passing through IDLE does not.
  assign is_toggle = commit && (((state == ST_ON)  && (dec_state == ST_OFF)) ||
                                ((state == ST_OFF) && (dec_state == ST_ON)));
  // num_in lags code_in by one cycle, so it lines up with code_q.
  assign mismatch_set = arm && code_legal && (num_in != exp_num);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= CODE_IDLE;
      cand   <= CODE_IDLE;
      run    <= '0;
      arm    <= 1'b0;
    end else begin
      code_q <= code_in;
      arm    <= 1'b1;
      if (code_legal) begin
        cand <= code_q;
        run  <= next_run;
      end else begin
        run  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_UNK;
      toggle     <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      toggle <= is_toggle;
      if (commit)
        state <= dec_state;
      if (is_toggle && (toggle_cnt != {CNT_W{1'b1}}))
        toggle_cnt <= toggle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_illegal  <= 1'b0;
      err_mismatch <= 1'b0;
    end else begin
      err_illegal  <= !code_legal   || (err_illegal  && !err_clr);
      err_mismatch <= mismatch_set  || (err_mismatch && !err_clr);
    end
  end

`ifdef SWITCH_DEC_GLITCH_CNT_EN
  logic glitch_set;
  assign glitch_set = code_legal && (code_q != cand) && (run != '0) && (run < RUN_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      glitch_cnt <= '0;
    end else if (glitch_set) begin
      if (glitch_cnt != {CNT_W{1'b1}})
        glitch_cnt <= glitch_cnt + CNT_W'(1);
    end else if (err_clr) begin
      glitch_cnt <= '0;
    end
  end
`endif

  assign state_out   = state;
  assign state_valid = (state != ST_UNK);

endmodule

// File: doc/switch_state_decoder.md
Name: switch_state_decoder

Overview:
- Receive-side decoder for the on/off switch status interface: consumes the 2-bit status code and the 3-bit registered number that the switch FSM block drives.
- Recovers the switch state through a stability filter, counts ON/OFF toggles, and flags illegal codes and code/number inconsistencies.
- Sits in the consumer domain on the same clock as the switch FSM. Its outputs feed status registers and interrupt logic.

Parameters:
STABLE_CYCLES, 2, consecutive identical legal samples required to commit a new state (legal range >=1)
CNT_W, 8, width of toggle_cnt (and glitch_cnt when enabled)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
code_in  input  2  status code: 2'h1=ON, 2'h3=OFF, 2'h0=IDLE, 2'h2=illegal
num_in  input  3  registered status number: ON=3'h2, OFF=3'h4, IDLE=3'h0
err_clr  input  1  single-cycle clear of sticky error flags
state_out  output  2  recovered state: 2'b00 UNK, 2'b01 ON, 2'b10 OFF, 2'b11 IDLE
state_valid  output  1  high when state_out != UNK
toggle  output  1  one-cycle pulse on each committed ON<->OFF transition
toggle_cnt  output  CNT_W  saturating count of toggle pulses
err_illegal  output  1  sticky: illegal code sampled
err_mismatch  output  1  sticky: num_in inconsistent with the previous code

Behaviour:
- Reset (rst=0, async) forces the following, all registered:
  - code_q=2'h0, cand=2'h0, run=0, arm=0
  - state=UNK, toggle=0, toggle_cnt=0
  - err_illegal=0, err_mismatch=0
- Input stage:
  - code_q <= code_in every cycle.
  - arm <= 1 at the first edge after reset release.
- Filter:
  - next_run = (code_q==cand) ? min(run+1, STABLE_CYCLES) : 1.
  - If code_q is legal: cand <= code_q, run <= next_run.
  - If code_q==2'h2: run <= 0 and cand is held.
- Commit:
  - Fires when code_q is legal, next_run==STABLE_CYCLES, and cand-decoded state != current state.
  - Action: state <= decoded(code_q).
  - Latency: a code_in change is visible on state_out STABLE_CYCLES+1 cycles later.
- FSM transitions (on commit only):
  - UNK -> ON/OFF/IDLE: no toggle.
  - ON <-> OFF: toggle=1 for exactly one cycle; toggle_cnt increments, saturating at all-ones (no wrap).
  - any <-> IDLE: no toggle, no count.
  - The FSM never returns to UNK except via reset.
- Mismatch check:
  - num_in at cycle t corresponds to code_in at cycle t-1, which is code_q at cycle t.
  - When arm=1 and code_q is legal and num_in != expected(code_q), err_mismatch <= 1.
  - No check when code_q is illegal.
- Illegal code: code_q==2'h2 sets err_illegal <= 1. Current state is held.
- Error clear:
  - err_clr clears both sticky flags.
  - A set condition in the same cycle wins: the flag stays 1.
- Reset mid-operation: all state is lost immediately (async). The filter restarts from run=0 after release.

Optional Feature:
- Macro: SWITCH_DEC_GLITCH_CNT_EN
- Defined:
  - Adds output port glitch_cnt [CNT_W-1:0], reset to 0.
  - Increments, saturating, each cycle a legal code_q differs from cand while 0<run<STABLE_CYCLES (a candidate abandoned before commit).
  - Cleared by err_clr; an increment in the same cycle wins.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then code_in=1, num_in tracking expected (STABLE_CYCLES=2) -> state_out=01 and state_valid=1 exactly 3 cycles after code_in applied; toggle=0; no errors.
- ON held, then code_in=3 -> state_out=10 after 3 cycles; toggle pulses one cycle; toggle_cnt=1. Repeat 300 alternations with CNT_W=8 -> toggle_cnt saturates at 255.
- From OFF, code_in=1 for one cycle, then back to 3 -> state stays 10, no toggle; with SWITCH_DEC_GLITCH_CNT_EN, glitch_cnt=1.
- code_in=2 for one cycle while ON -> err_illegal=1 sticky, state stays 01. err_clr pulse -> 0. err_clr coincident with a second code 2 -> stays 1.
- Stable code_in=1 but num_in=3'h4 -> err_mismatch=1 at the next edge. Same stimulus on the first cycle after reset (arm=0) -> no flag.
- Assert rst=0 mid-transition (run=1) -> all outputs zero asynchronously, state_out=00. After release, a full STABLE_CYCLES+1 latency is required again.
